// File: rtl/tow_opponent_center.sv
// Computer opponent and center light for the tug-of-war game: a free-running
// LFSR, a difficulty comparator with a one-cycle press pulse, and the center cell.
module tow_opponent_center #(
    parameter int LFSR_W = 10,
    parameter int DIFF_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIFF_W-1:0] difficulty,
    input  logic              round_reset,
    input  logic              human_move,
    input  logic              nl,
    input  logic              nr,
    output logic [LFSR_W-1:0] random,
    output logic              comp_move,
    output logic              comp_pulse,
    output logic              center_on
);

    // x^10 + x^7 + 1: taps at the top bit and three below it.
    localparam int TAP_HI = LFSR_W - 1;
    localparam int TAP_LO = LFSR_W - 4;

    logic [LFSR_W-1:0] r_random;
    logic              r_prev_move;
    logic              r_comp_pulse;
    logic              r_center_on;

    logic              w_lfsr_fb;
    logic [LFSR_W-1:0] w_lfsr_next;
    logic [LFSR_W-1:0] w_diff_ext;
    logic              w_comp_move;
    logic              w_pulse_next;
    logic              w_center_next;

    // XNOR feedback makes all-zeros a legal start and all-ones the lock-up state.
    assign w_lfsr_fb   = ~(r_random[TAP_HI] ^ r_random[TAP_LO]);
    assign w_lfsr_next = {r_random[LFSR_W-2:0], w_lfsr_fb};

    assign w_diff_ext  = {{(LFSR_W - DIFF_W){1'b0}}, difficulty};
    assign w_comp_move = (w_diff_ext > r_random);

    assign w_pulse_next = w_comp_move & ~r_prev_move;

    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_center_next = r_center_on;
        if (round_reset) begin
            w_center_next = 1'b1;
        end else begin
            w_center_next = (nl & human_move & ~r_comp_pulse)
                          | (nr & r_comp_pulse & ~human_move)
                          | (r_center_on & ~(human_move ^ r_comp_pulse));
        end
    end

    // The LFSR and the pulse detector ignore round_reset; only the light relights.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_random     <= '0;
            r_prev_move  <= 1'b0;
            r_comp_pulse <= 1'b0;
            r_center_on  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values of the others.
            r_random     <= w_lfsr_next;
            r_prev_move  <= w_comp_move;
            r_comp_pulse <= w_pulse_next;
            r_center_on  <= w_center_next;
        end
    end

    assign random     = r_random;
    assign comp_move  = w_comp_move;
    assign comp_pulse = r_comp_pulse;
    assign center_on  = r_center_on;

endmodule

// File: tb/tb_tow_opponent_center.sv
// Directed self-checking bench for tow_opponent_center.
module tb_tow_opponent_center;

    logic       clk;
    logic       reset;
    logic [8:0] difficulty;
    logic       round_reset;
    logic       human_move;
    logic       nl;
    logic       nr;
    logic [9:0] random;
    logic       comp_move;
    logic       comp_pulse;
    logic       center_on;

    int n_checks;
    int n_fail;

    tow_opponent_center #(.LFSR_W(10), .DIFF_W(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .difficulty (difficulty),
        .round_reset(round_reset),
        .human_move (human_move),
        .nl         (nl),
        .nr         (nr),
        .random     (random),
        .comp_move  (comp_move),
        .comp_pulse (comp_pulse),
        .center_on  (center_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] lfsr_next(input logic [9:0] r);
        return {r[8:0], ~(r[9] ^ r[6])};
    endfunction

    // Hold reset for one full cycle with the given difficulty and quiet inputs;
    // returns at a falling edge with reset still asserted.
    task automatic hold_reset(input logic [8:0] diff);
        @(negedge clk);
        reset       = 1'b0;
        difficulty  = diff;
        round_reset = 1'b0;
        human_move  = 1'b0;
        nl          = 1'b0;
        nr          = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] exp_seq [4];
        exp_seq[0] = 10'h001; exp_seq[1] = 10'h003; exp_seq[2] = 10'h007; exp_seq[3] = 10'h00F;
        hold_reset(9'd0);
        #1;
        n_checks++; if (random !== 10'h000) begin n_fail++; $display("FAIL reset_random got=%h exp=000", random); end
        n_checks++; if (center_on !== 1'b1) begin n_fail++; $display("FAIL reset_center got=%b exp=1", center_on); end
        n_checks++; if (comp_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0", comp_pulse); end
        n_checks++; if (comp_move !== 1'b0) begin n_fail++; $display("FAIL reset_move_d0 got=%b exp=0", comp_move); end
        difficulty = 9'd5;
        #1;
        n_checks++; if (comp_move !== 1'b1) begin n_fail++; $display("FAIL reset_move_d5 got=%b exp=1", comp_move); end
        difficulty = 9'd0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (random !== exp_seq[i]) begin
                n_fail++; $display("FAIL lfsr_seq[%0d] got=%h exp=%h", i, random, exp_seq[i]);
            end
        end
    endtask

    task automatic test_diff_zero();
        hold_reset(9'd0);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++; if (comp_move !== 1'b0) begin n_fail++; $display("FAIL d0_move cyc=%0d got=%b exp=0", i, comp_move); end
            n_checks++; if (comp_pulse !== 1'b0) begin n_fail++; $display("FAIL d0_pulse cyc=%0d got=%b exp=0", i, comp_pulse); end
            n_checks++; if (center_on !== 1'b1) begin n_fail++; $display("FAIL d0_center cyc=%0d got=%b exp=1", i, center_on); end
        end
    endtask

    task automatic test_diff_two();
        hold_reset(9'd2);
        #1;
        n_checks++; if (comp_move !== 1'b1) begin n_fail++; $display("FAIL d2_move_r0 got=%b exp=1", comp_move); end
        n_checks++; if (comp_pulse !== 1'b0) begin n_fail++; $display("FAIL d2_pulse_rst got=%b exp=0", comp_pulse); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (random !== 10'h001) begin n_fail++; $display("FAIL d2_random1 got=%h exp=001", random); end
        n_checks++; if (comp_move !== 1'b1) begin n_fail++; $display("FAIL d2_move_r1 got=%b exp=1", comp_move); end
        n_checks++; if (comp_pulse !== 1'b1) begin n_fail++; $display("FAIL d2_pulse_first got=%b exp=1", comp_pulse); end
        @(negedge clk);
        n_checks++; if (random !== 10'h003) begin n_fail++; $display("FAIL d2_random3 got=%h exp=003", random); end
        n_checks++; if (comp_move !== 1'b0) begin n_fail++; $display("FAIL d2_move_r3 got=%b exp=0", comp_move); end
        n_checks++; if (comp_pulse !== 1'b0) begin n_fail++; $display("FAIL d2_pulse_second got=%b exp=0", comp_pulse); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (comp_pulse !== 1'b0) begin n_fail++; $display("FAIL d2_pulse_later cyc=%0d got=%b exp=0", i, comp_pulse); end
        end
    endtask

    task automatic test_center_human();
        hold_reset(9'd0);
        reset      = 1'b1;
        human_move = 1'b1;
        @(negedge clk);
        n_checks++; if (center_on !== 1'b0) begin n_fail++; $display("FAIL hum_off got=%b exp=0", center_on); end
        nl = 1'b1;
        @(negedge clk);
        n_checks++; if (center_on !== 1'b1) begin n_fail++; $display("FAIL hum_from_left got=%b exp=1", center_on); end
        human_move = 1'b0;
        nl = 1'b0;
        @(negedge clk);
        n_checks++; if (center_on !== 1'b1) begin n_fail++; $display("FAIL hum_hold got=%b exp=1", center_on); end
    endtask

    // Center dark, then a computer pulse with nr lit; variant 1 adds a
    // simultaneous human pull, which must cancel and leave the center dark.
    task automatic test_center_comp();
        for (int v = 0; v < 2; v++) begin
            hold_reset(9'd0);
            reset      = 1'b1;
            human_move = 1'b1;
            @(negedge clk);
            n_checks++; if (center_on !== 1'b0) begin n_fail++; $display("FAIL comp_pre_off v=%0d got=%b exp=0", v, center_on); end
            human_move = 1'b0;
            difficulty = 9'd511;
            #1;
            n_checks++; if (comp_move !== 1'b1) begin n_fail++; $display("FAIL comp_move_511 v=%0d got=%b exp=1", v, comp_move); end
            @(negedge clk);
            n_checks++; if (comp_pulse !== 1'b1) begin n_fail++; $display("FAIL comp_pulse_511 v=%0d got=%b exp=1", v, comp_pulse); end
            n_checks++; if (center_on !== 1'b0) begin n_fail++; $display("FAIL comp_still_off v=%0d got=%b exp=0", v, center_on); end
            nr = 1'b1;
            human_move = (v == 1);
            @(negedge clk);
            n_checks++;
            if (center_on !== (v == 0)) begin
                n_fail++; $display("FAIL comp_from_right v=%0d got=%b exp=%b", v, center_on, (v == 0));
            end
            n_checks++; if (comp_pulse !== 1'b0) begin n_fail++; $display("FAIL comp_pulse_once v=%0d got=%b exp=0", v, comp_pulse); end
            nr = 1'b0;
            human_move = 1'b0;
        end
    endtask

    // Let the LFSR run at difficulty 511 until it falls from >=511 to <511;
    // comp_move must rise at once and comp_pulse one cycle later.
    task automatic test_pulse_crossing();
        logic [9:0] r_model;
        logic [9:0] prev_model;
        bit         found;
        hold_reset(9'd511);
        reset   = 1'b1;
        r_model = 10'h000;
        found   = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            @(negedge clk);
            prev_model = r_model;
            r_model    = lfsr_next(r_model);
            n_checks++;
            if (random !== r_model) begin
                n_fail++; $display("FAIL cross_random cyc=%0d got=%h exp=%h", i, random, r_model);
            end
            if (prev_model >= 10'd511 && r_model < 10'd511) begin
                found = 1'b1;
                n_checks++; if (comp_move !== 1'b1) begin n_fail++; $display("FAIL cross_move got=%b exp=1", comp_move); end
                n_checks++; if (comp_pulse !== 1'b0) begin n_fail++; $display("FAIL cross_pulse_early got=%b exp=0", comp_pulse); end
                @(negedge clk);
                n_checks++; if (comp_pulse !== 1'b1) begin n_fail++; $display("FAIL cross_pulse got=%b exp=1", comp_pulse); end
                @(negedge clk);
                n_checks++; if (comp_pulse !== 1'b0) begin n_fail++; $display("FAIL cross_pulse_after got=%b exp=0", comp_pulse); end
            end
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL cross_timeout got=no_crossing exp=crossing_within_1100");
        end
    endtask

    task automatic test_round_reset();
        logic [9:0] r_model;
        hold_reset(9'd0);
        reset      = 1'b1;
        human_move = 1'b1;
        r_model    = 10'h000;
        @(negedge clk);
        r_model = lfsr_next(r_model);
        n_checks++; if (center_on !== 1'b0) begin n_fail++; $display("FAIL rr_pre_off got=%b exp=0", center_on); end
        human_move  = 1'b0;
        round_reset = 1'b1;
        @(negedge clk);
        r_model = lfsr_next(r_model);
        n_checks++; if (center_on !== 1'b1) begin n_fail++; $display("FAIL rr_relight got=%b exp=1", center_on); end
        n_checks++; if (random !== r_model) begin n_fail++; $display("FAIL rr_random got=%h exp=%h", random, r_model); end
        human_move = 1'b1;
        @(negedge clk);
        r_model = lfsr_next(r_model);
        n_checks++; if (center_on !== 1'b1) begin n_fail++; $display("FAIL rr_over_human got=%b exp=1", center_on); end
        n_checks++; if (random !== r_model) begin n_fail++; $display("FAIL rr_random2 got=%h exp=%h", random, r_model); end
        round_reset = 1'b0;
        human_move  = 1'b0;
        @(negedge clk);
        r_model = lfsr_next(r_model);
        n_checks++; if (random !== r_model) begin n_fail++; $display("FAIL rr_random3 got=%h exp=%h", random, r_model); end
    endtask

    task automatic test_async_reset();
        hold_reset(9'd2);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        n_checks++; if (random !== 10'h01F) begin n_fail++; $display("FAIL ar_pre_random got=%h exp=01f", random); end
        n_checks++; if (center_on !== 1'b0) begin n_fail++; $display("FAIL ar_pre_center got=%b exp=0", center_on); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (random !== 10'h000) begin n_fail++; $display("FAIL ar_random got=%h exp=000", random); end
        n_checks++; if (center_on !== 1'b1) begin n_fail++; $display("FAIL ar_center got=%b exp=1", center_on); end
        n_checks++; if (comp_pulse !== 1'b0) begin n_fail++; $display("FAIL ar_pulse got=%b exp=0", comp_pulse); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (random !== 10'h001) begin n_fail++; $display("FAIL ar_resume got=%h exp=001", random); end
        n_checks++; if (comp_pulse !== 1'b1) begin n_fail++; $display("FAIL ar_resume_pulse got=%b exp=1", comp_pulse); end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        difficulty  = '0;
        round_reset = 1'b0;
        human_move  = 1'b0;
        nl          = 1'b0;
        nr          = 1'b0;

        test_reset();
        test_diff_zero();
        test_diff_two();
        test_center_human();
        test_center_comp();
        test_pulse_crossing();
        test_round_reset();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
